// File: rtl/cmd_executor.sv
// cmd_executor: pops parsed commands from the command FIFO, performs one
// single-byte register access per command and pushes a two-byte
// (status, data) response into the UART TX byte FIFO. One command at a time.
module cmd_executor #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_fifo_empty,
    input  logic [17:0] cmd_fifo_rd_data,
    output logic        cmd_fifo_rd_en,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    input  logic [7:0]  reg_rdata,
    input  logic        reg_rdata_valid,
    input  logic        tx_fifo_full,
    output logic        tx_fifo_wr_en,
    output logic [7:0]  tx_fifo_wr_data,
    output logic        busy,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP_STAT,
        RESP_DATA
    } state_t;

    localparam logic [1:0] CMD_PING  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    localparam logic [7:0] ST_PING     = 8'hA0;
    localparam logic [7:0] ST_WRITE    = 8'hA1;
    localparam logic [7:0] ST_READ_OK  = 8'hA2;
    localparam logic [7:0] ST_INVALID  = 8'hE1;
    localparam logic [7:0] ST_TIMEOUT  = 8'hE2;

    // Last counter value before the read is declared timed out.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [17:0] cmd_q;
    logic [15:0] tmo_cnt;
    logic [7:0]  stat_q;
    logic [7:0]  data_q;
    logic [1:0]  cmd_type;

    // Saturating +1 used for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign cmd_type  = cmd_q[17:16];
    assign reg_addr  = cmd_q[15:8];
    assign reg_wdata = cmd_q[7:0];

    // Pop and push handshakes are combinational so a ready FIFO costs no extra cycle.
    assign cmd_fifo_rd_en  = (state == IDLE) && !cmd_fifo_empty;
    assign tx_fifo_wr_en   = ((state == RESP_STAT) || (state == RESP_DATA)) && !tx_fifo_full;
    assign tx_fifo_wr_data = (state == RESP_DATA) ? data_q : stat_q;

    // Command FSM: capture, issue the register strobe, collect read data, send response.
    // NOTE: every register here uses <= so all updates land together at the clock edge;
    // a blocking = would let later statements see half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_q     <= '0;
            tmo_cnt   <= '0;
            stat_q    <= '0;
            data_q    <= '0;
            err_count <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Register strobes live for exactly the ISSUE cycle.
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fifo_rd_en) begin
                        cmd_q     <= cmd_fifo_rd_data;
                        reg_wr_en <= (cmd_fifo_rd_data[17:16] == CMD_WRITE);
                        reg_rd_en <= (cmd_fifo_rd_data[17:16] == CMD_READ);
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    case (cmd_type)
                        CMD_PING: begin
                            stat_q <= ST_PING;
                            data_q <= reg_addr;
                            state  <= RESP_STAT;
                        end
                        CMD_WRITE: begin
                            stat_q <= ST_WRITE;
                            data_q <= reg_wdata;
                            state  <= RESP_STAT;
                        end
                        CMD_READ: begin
                            tmo_cnt <= '0;
                            state   <= WAIT_RD;
                        end
                        default: begin
                            stat_q    <= ST_INVALID;
                            data_q    <= 8'h00;
                            err_count <= sat_inc(err_count);
                            state     <= RESP_STAT;
                        end
                    endcase
                end
                WAIT_RD: begin
                    // Valid data takes priority over a timeout in the same cycle.
                    if (reg_rdata_valid) begin
                        stat_q <= ST_READ_OK;
                        data_q <= reg_rdata;
                        state  <= RESP_STAT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        stat_q    <= ST_TIMEOUT;
                        data_q    <= 8'h00;
                        err_count <= sat_inc(err_count);
                        state     <= RESP_STAT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RESP_STAT: begin
                    if (!tx_fifo_full) state <= RESP_DATA;
                end
                RESP_DATA: begin
                    if (!tx_fifo_full) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
